ja_intersection_ctrl: RTL
=========================

JA_INTERSECTION_CTRL -- requirements
Module: ja_intersection_ctrl

Interface
REQ-001 SHALL have parameter N_PHASES, default 2, meaning number of conflicting signal groups (legal 2..4).
REQ-002 SHALL have parameter CNT_W, default 6, meaning width of the dwell counter and duration parameters.
REQ-003 SHALL have parameter DIV_W, default 8, meaning width of the tick divider.
REQ-004 SHALL have parameters T_GREEN, T_YELLOW and T_ALLRED, defaults 20, 3 and 2, meaning dwell in ticks for each state (legal 1..2^CNT_W-1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: run request, level-sensitive.
REQ-008 SHALL have port flash, input, 1 bit: night/fault mode request, level-sensitive.
REQ-009 SHALL have port tick_div, input, DIV_W bits: a tick occurs every tick_div+1 clocks.
REQ-010 SHALL have port ped_req, input, N_PHASES bits: pedestrian request per phase, 1-clock pulses allowed.
REQ-011 SHALL have ports red, yellow, green and walk, outputs, N_PHASES bits each: lamp drives per phase.
REQ-012 SHALL have port phase_idx, output, $clog2(N_PHASES) bits: index of the current or most recently served phase.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, ALLRED, GREEN, YELLOW and FLASH; all outputs SHALL be registered.
REQ-015 IDLE SHALL drive all red=1 and all other lamps 0; when start=1 and flash=0 it SHALL go to ALLRED with phase_idx=0 on the next clock.
REQ-016 Sequence SHALL be ALLRED -> GREEN(p) -> YELLOW(p) -> ALLRED -> GREEN((p+1) mod N_PHASES), where p is phase_idx.
REQ-017 In GREEN(p), green[p]=1 and red=1 for all other phases; in YELLOW(p), yellow[p]=1 and red=1 for all other phases; in ALLRED, all red=1.
REQ-018 The tick prescaler SHALL restart on every state change, and tick_div SHALL be sampled at state entry, so that a state of dwell D lasts exactly D*(tick_div+1) clocks; tick_div=0 means one tick per clock.
REQ-019 The dwell counter SHALL clear on state entry; the state SHALL exit on the tick at which counter == D-1.
REQ-020 ped_req[i] SHALL set a sticky latch; on entry to GREEN(i), walk[i] SHALL assert for the whole green and the latch SHALL clear.
REQ-021 A ped_req[i] arriving during GREEN(i) SHALL stay latched for the next GREEN(i) and SHALL NOT assert walk in the current green.
REQ-022 walk SHALL be 0 in every state other than GREEN.
REQ-023 If start=0 at the end of ALLRED, the block SHALL go to IDLE instead of GREEN; start=0 SHALL never shorten GREEN or YELLOW.
REQ-024 If flash=1, the block SHALL enter FLASH on the next clock from any state.
REQ-025 In FLASH, red=green=walk=0 and all yellow bits SHALL toggle together on every tick, starting at 1.
REQ-026 When flash falls, the block SHALL go to ALLRED with phase_idx=0, and SHALL then follow REQ-023.
REQ-027 If flash and start change in the same clock, flash SHALL have priority.
REQ-028 The output must never show green or yellow on two phases at once; green and walk must never be asserted on a phase whose red=1.

Reset
REQ-029 While rst_n=0, the block SHALL be in IDLE with red all 1, yellow/green/walk all 0, phase_idx=0, busy=0, the ped latches clear, and the counter and prescaler zero.
REQ-030 When rst_n is asserted in mid-operation, the block SHALL drop to IDLE immediately (asynchronously); after release, the first state change SHALL occur on the first rising edge that sees start=1.

Structure
REQ-031 The state enumeration, the default durations and the lamp-pattern constants SHALL reside in the shared package ja_tl_pkg.
REQ-032 The prescaler SHALL be a separate sub-module ja_tick_gen (inputs: clk, rst_n, restart, div; output: tick pulse).

Verification
REQ-033 Verification SHALL use N_PHASES=2, T_GREEN=4, T_YELLOW=2, T_ALLRED=1 and tick_div=0. Stimulus: start=1. Required response: ALLRED 1 clk, green[0] 4 clk, yellow[0] 2 clk, ALLRED 1 clk, green[1] 4 clk; period 14 clk.
REQ-034 Stimulus: tick_div=3. Required response: green[0] lasts exactly 16 clocks and yellow[0] exactly 8 clocks.
REQ-035 Stimulus: ped_req[1] pulsed during GREEN(0), and ped_req[0] pulsed during GREEN(0). Required response: walk[1]=1 for all of GREEN(1); walk[0] stays 0 until the next GREEN(0), then is 1.
REQ-036 Stimulus: start dropped mid-GREEN(1). Required response: full green and yellow, then ALLRED, then IDLE, busy=0.
REQ-037 Stimulus: flash=1 during GREEN(0) with tick_div=1. Required response: next clock all lamps off except yellow=2'b11, toggling every 2 clocks; flash=0 leads to ALLRED then green[0].
REQ-038 Stimulus: rst_n pulsed low mid-YELLOW. Required response: immediate red=2'b11, green=yellow=walk=0, latched ped requests lost; the bench SHALL check REQ-028 on every clock.

Source files
------------

// File: rtl/ja_tl_pkg.sv
// ja_tl_pkg: shared definitions for the intersection controller.
//   - tl_state_t  : controller state enumeration
//   - DEF_T_*     : default dwell durations, in ticks
//   - lamp_t      : one phase's lamp triple {r, y, g}, plus the fixed patterns
package ja_tl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALLRED,
    ST_GREEN,
    ST_YELLOW,
    ST_FLASH
  } tl_state_t;

  localparam int DEF_T_GREEN  = 20;
  localparam int DEF_T_YELLOW = 3;
  localparam int DEF_T_ALLRED = 2;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  localparam lamp_t LAMP_RED  = '{r: 1'b1, y: 1'b0, g: 1'b0};
  localparam lamp_t LAMP_YEL  = '{r: 1'b0, y: 1'b1, g: 1'b0};
  localparam lamp_t LAMP_GRN  = '{r: 1'b0, y: 1'b0, g: 1'b1};
  localparam lamp_t LAMP_DARK = '{r: 1'b0, y: 1'b0, g: 1'b0};

endpackage

// File: rtl/ja_tick_gen.sv
// ja_tick_gen: restartable tick prescaler.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   restart - clears the divider and captures div (used at every state entry)
//   div     - divide value; a tick occurs every div+1 clocks
//   tick    - one-clock tick pulse
module ja_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] div_reg;

  // The divide value is captured on restart so a change of div in
  // mid-state never alters the length of the state in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      div_reg <= '0;
    end else if (restart) begin
      cnt_reg <= '0;
      div_reg <= div;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + DIV_W'(1);
    end
  end

  assign tick = (cnt_reg == div_reg);

endmodule

// File: rtl/ja_intersection_ctrl.sv
// ja_intersection_ctrl: fixed-time traffic light controller for N_PHASES
// conflicting signal groups, with pedestrian latches and a flashing mode.
// Ports:
//   clk       - clock
//   rst_n     - asynchronous active-low reset
//   start     - run request (level)
//   flash     - night/fault flashing request (level, highest priority)
//   tick_div  - a dwell tick occurs every tick_div+1 clocks
//   ped_req   - pedestrian request pulse per phase
//   red/yellow/green/walk - registered lamp drives per phase
//   phase_idx - current or most recently served phase
//   busy      - high outside IDLE
module ja_intersection_ctrl #(
  parameter int N_PHASES = 2,
  parameter int CNT_W    = 6,
  parameter int DIV_W    = 8,
  parameter int T_GREEN  = ja_tl_pkg::DEF_T_GREEN,
  parameter int T_YELLOW = ja_tl_pkg::DEF_T_YELLOW,
  parameter int T_ALLRED = ja_tl_pkg::DEF_T_ALLRED,
  localparam int PW      = $clog2(N_PHASES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                flash,
  input  logic [DIV_W-1:0]    tick_div,
  input  logic [N_PHASES-1:0] ped_req,
  output logic [N_PHASES-1:0] red,
  output logic [N_PHASES-1:0] yellow,
  output logic [N_PHASES-1:0] green,
  output logic [N_PHASES-1:0] walk,
  output logic [PW-1:0]       phase_idx,
  output logic                busy
);
  import ja_tl_pkg::*;

  tl_state_t           state_reg, state_next;
  logic [PW-1:0]       phase_reg, phase_next;
  logic [PW-1:0]       serve_reg, serve_next;   // phase the next green will serve
  logic [CNT_W-1:0]    dwell_reg, dwell_next;
  logic [N_PHASES-1:0] ped_reg, ped_next;
  logic [N_PHASES-1:0] walk_reg, walk_next;
  logic [N_PHASES-1:0] red_reg, red_next;
  logic [N_PHASES-1:0] yellow_reg, yellow_next;
  logic [N_PHASES-1:0] green_reg, green_next;
  logic                busy_reg, busy_next;
  logic [CNT_W-1:0]    dur;
  logic                done;
  logic                tick;
  logic                restart;
  logic                flash_y;
  lamp_t               lamp;

  ja_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .div     (tick_div),
    .tick    (tick)
  );

  // Dwell length of the current state and its terminal-tick condition.
  always_comb begin
    dur = CNT_W'(1);
    case (state_reg)
      ST_GREEN:  dur = CNT_W'(T_GREEN);
      ST_YELLOW: dur = CNT_W'(T_YELLOW);
      ST_ALLRED: dur = CNT_W'(T_ALLRED);
      default:   dur = CNT_W'(1);
    endcase
  end

  assign done = tick && (dwell_reg == dur - CNT_W'(1));

  // Next-state logic. flash overrides everything, including start.
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    serve_next = serve_reg;
    if (flash) begin
      state_next = ST_FLASH;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_next = ST_ALLRED;
            phase_next = '0;
            serve_next = '0;
          end
        end
        ST_ALLRED: begin
          if (done) begin
            if (start) begin
              state_next = ST_GREEN;
              phase_next = serve_reg;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_GREEN: begin
          if (done) state_next = ST_YELLOW;
        end
        ST_YELLOW: begin
          if (done) begin
            state_next = ST_ALLRED;
            serve_next = (phase_reg == PW'(N_PHASES - 1)) ? '0 : phase_reg + PW'(1);
          end
        end
        ST_FLASH: begin
          state_next = ST_ALLRED;
          phase_next = '0;
          serve_next = '0;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Every state change restarts both the prescaler and the dwell count.
  assign restart = (state_next != state_reg);

  always_comb begin
    dwell_next = dwell_reg;
    if (restart)   dwell_next = '0;
    else if (tick) dwell_next = dwell_reg + CNT_W'(1);
  end

  // Output patterns are computed from the next state so that the lamp
  // registers change on the same edge as the state register.
  always_comb begin
    ped_next    = ped_reg | ped_req;
    walk_next   = '0;
    red_next    = '0;
    yellow_next = '0;
    green_next  = '0;
    busy_next   = (state_next != ST_IDLE);
    lamp        = LAMP_DARK;
    // Flash yellow starts lit on entry and toggles on each tick after.
    flash_y     = (state_reg != ST_FLASH) ? 1'b1 : (tick ? ~yellow_reg[0] : yellow_reg[0]);
    for (int i = 0; i < N_PHASES; i++) begin
      lamp = LAMP_RED;
      if (phase_next == PW'(i)) begin
        case (state_next)
          ST_GREEN: begin
            lamp = LAMP_GRN;
            // Requests are consumed only on green entry; one arriving
            // during this green stays latched for the next one.
            if (state_reg != ST_GREEN) begin
              walk_next[i] = ped_reg[i] | ped_req[i];
              ped_next[i]  = 1'b0;
            end else begin
              walk_next[i] = walk_reg[i];
            end
          end
          ST_YELLOW: lamp = LAMP_YEL;
          default:   lamp = LAMP_RED;
        endcase
      end
      if (state_next == ST_FLASH) lamp = flash_y ? LAMP_YEL : LAMP_DARK;
      red_next[i]    = lamp.r;
      yellow_next[i] = lamp.y;
      green_next[i]  = lamp.g;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      phase_reg  <= '0;
      serve_reg  <= '0;
      dwell_reg  <= '0;
      ped_reg    <= '0;
      walk_reg   <= '0;
      red_reg    <= '1;
      yellow_reg <= '0;
      green_reg  <= '0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      serve_reg  <= serve_next;
      dwell_reg  <= dwell_next;
      ped_reg    <= ped_next;
      walk_reg   <= walk_next;
      red_reg    <= red_next;
      yellow_reg <= yellow_next;
      green_reg  <= green_next;
      busy_reg   <= busy_next;
    end
  end

  assign red       = red_reg;
  assign yellow    = yellow_reg;
  assign green     = green_reg;
  assign walk      = walk_reg;
  assign phase_idx = phase_reg;
  assign busy      = busy_reg;

endmodule
